// File: rtl/h264_pkg.sv
// Shared types and constants for the macroblock fetch scheduler.
package h264_pkg;

    typedef enum logic [1:0] {
        PLANE_Y = 2'd0,
        PLANE_U = 2'd1,
        PLANE_V = 2'd2
    } plane_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_Y,
        ST_FETCH_U,
        ST_FETCH_V,
        ST_DRAIN,
        ST_WAIT_ACK,
        ST_DONE
    } fetch_state_e;

    localparam int MB_Y_WORDS  = 64;
    localparam int MB_C_WORDS  = 16;
    localparam int MB_WORDS    = 96;
    localparam int Y_ROW_WORDS = 4;
    localparam int C_ROW_WORDS = 2;

    function automatic plane_e state_plane(input fetch_state_e s);
        case (s)
            ST_FETCH_U: return PLANE_U;
            ST_FETCH_V: return PLANE_V;
            default:    return PLANE_Y;
        endcase
    endfunction

endpackage

// File: rtl/h264_mb_addr_gen.sv
// Word-address generator: tracks MB and row base addresses incrementally,
// so no multiplier is needed; fetch_addr is the current row base plus column.
module h264_mb_addr_gen #(
    parameter int          MB_W   = 11,
    parameter logic [31:0] Y_BASE = 32'd0,
    parameter logic [31:0] U_BASE = 32'd6336,
    parameter logic [31:0] V_BASE = 32'd7920
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        frame_start_i,
    input  logic        mb_next_i,
    input  logic        adv_i,
    input  logic        col_last_i,
    input  logic        row_last_i,
    input  logic [1:0]  plane_i,
    input  logic [1:0]  col_i,
    input  logic [5:0]  mb_x_i,
    output logic [31:0] fetch_addr_o
);
    import h264_pkg::*;

    localparam logic [31:0] Y_STRIDE = 32'(MB_W * Y_ROW_WORDS);
    localparam logic [31:0] C_STRIDE = 32'(MB_W * C_ROW_WORDS);
    localparam logic [31:0] Y_STEP   = 32'(Y_ROW_WORDS);
    localparam logic [31:0] C_STEP   = 32'(C_ROW_WORDS);
    // Jump from the last MB of a row to the first MB of the next MB row.
    localparam logic [31:0] Y_WRAP   = 32'(MB_W * MB_Y_WORDS - (MB_W - 1) * Y_ROW_WORDS);
    localparam logic [31:0] C_WRAP   = 32'(MB_W * MB_C_WORDS - (MB_W - 1) * C_ROW_WORDS);

    logic [31:0] y_mb_q, y_mb_d;
    logic [31:0] c_mb_q, c_mb_d;
    logic [31:0] row_base_q, row_base_d;
    logic        wrap;

    assign wrap = (mb_x_i == 6'(MB_W - 1));

    always_comb begin
        y_mb_d     = y_mb_q;
        c_mb_d     = c_mb_q;
        row_base_d = row_base_q;
        if (frame_start_i) begin
            y_mb_d     = Y_BASE;
            c_mb_d     = 32'd0;
            row_base_d = Y_BASE;
        end else if (mb_next_i) begin
            y_mb_d     = y_mb_q + (wrap ? Y_WRAP : Y_STEP);
            c_mb_d     = c_mb_q + (wrap ? C_WRAP : C_STEP);
            row_base_d = y_mb_d;
        end else if (adv_i && col_last_i) begin
            if (!row_last_i) begin
                row_base_d = row_base_q + ((plane_i == PLANE_Y) ? Y_STRIDE : C_STRIDE);
            end else if (plane_i == PLANE_Y) begin
                row_base_d = U_BASE + c_mb_q;
            end else if (plane_i == PLANE_U) begin
                row_base_d = V_BASE + c_mb_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            y_mb_q     <= Y_BASE;
            c_mb_q     <= 32'd0;
            row_base_q <= Y_BASE;
        end else begin
            y_mb_q     <= y_mb_d;
            c_mb_q     <= c_mb_d;
            row_base_q <= row_base_d;
        end
    end

    assign fetch_addr_o = row_base_q + {30'd0, col_i};

endmodule

// File: rtl/h264_mb_fetch_ctrl.sv
// Frame-level MB fetch scheduler: walks MBs in raster order, fetches Y/U/V
// words and forwards them through a one-deep tagged output register.
module h264_mb_fetch_ctrl #(
    parameter int          MB_W   = 11,
    parameter int          MB_H   = 9,
    parameter logic [31:0] Y_BASE = 32'd0,
    parameter logic [31:0] U_BASE = 32'd6336,
    parameter logic [31:0] V_BASE = 32'd7920
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic [31:0] fetch_addr_o,
    input  logic [31:0] data_word_i,
    input  logic        data_valid_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic [1:0]  out_plane_o,
    output logic [3:0]  out_row_o,
    output logic [1:0]  out_col_o,
    output logic [5:0]  mb_x_o,
    output logic [5:0]  mb_y_o,
    output logic        mb_done_o,
    input  logic        mb_ack_i,
    output logic        busy_o,
    output logic        frame_done_o
);
    import h264_pkg::*;

    fetch_state_e state_q, state_d;
    logic [3:0]   row_q, row_d;
    logic [1:0]   col_q, col_d;
    logic [5:0]   mb_x_q, mb_x_d, mb_y_q, mb_y_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_data_q, out_data_d;
    plane_e       out_plane_q, out_plane_d;
    logic [3:0]   out_row_q, out_row_d;
    logic [1:0]   out_col_q, out_col_d;

    plane_e cur_plane;
    logic   in_fetch, acc, col_last, row_last, frame_start, mb_next;

    assign cur_plane = state_plane(state_q);
    assign in_fetch  = state_q inside {ST_FETCH_Y, ST_FETCH_U, ST_FETCH_V};
    assign acc       = in_fetch && data_valid_i && (!out_valid_q || out_ready_i);
    assign col_last  = (cur_plane == PLANE_Y) ? (col_q == 2'd3) : (col_q == 2'd1);
    assign row_last  = (cur_plane == PLANE_Y) ? (row_q == 4'd15) : (row_q == 4'd7);

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        mb_x_d       = mb_x_q;
        mb_y_d       = mb_y_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_plane_d  = out_plane_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        frame_start  = 1'b0;
        mb_next      = 1'b0;
        mb_done_o    = 1'b0;
        frame_done_o = 1'b0;

        if (acc) begin
            out_valid_d = 1'b1;
            out_data_d  = data_word_i;
            out_plane_d = cur_plane;
            out_row_d   = row_q;
            out_col_d   = col_q;
            if (!col_last) begin
                col_d = col_q + 2'd1;
            end else if (!row_last) begin
                col_d = 2'd0;
                row_d = row_q + 4'd1;
            end else begin
                // After the final V word the counters park on it until the next MB.
                case (cur_plane)
                    PLANE_Y: begin state_d = ST_FETCH_U; row_d = 4'd0; col_d = 2'd0; end
                    PLANE_U: begin state_d = ST_FETCH_V; row_d = 4'd0; col_d = 2'd0; end
                    default: state_d = ST_DRAIN;
                endcase
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_FETCH_Y;
                    mb_x_d      = 6'd0;
                    mb_y_d      = 6'd0;
                    row_d       = 4'd0;
                    col_d       = 2'd0;
                    frame_start = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready_i) begin
                    mb_done_o = 1'b1;
                    state_d   = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (mb_ack_i) begin
                    if (mb_x_q == 6'(MB_W - 1) && mb_y_q == 6'(MB_H - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH_Y;
                        mb_next = 1'b1;
                        row_d   = 4'd0;
                        col_d   = 2'd0;
                        if (mb_x_q == 6'(MB_W - 1)) begin
                            mb_x_d = 6'd0;
                            mb_y_d = mb_y_q + 6'd1;
                        end else begin
                            mb_x_d = mb_x_q + 6'd1;
                        end
                    end
                end
            end
            ST_DONE: begin
                frame_done_o = 1'b1;
                state_d      = ST_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            row_q       <= 4'd0;
            col_q       <= 2'd0;
            mb_x_q      <= 6'd0;
            mb_y_q      <= 6'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_plane_q <= PLANE_Y;
            out_row_q   <= 4'd0;
            out_col_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            mb_x_q      <= mb_x_d;
            mb_y_q      <= mb_y_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_plane_q <= out_plane_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

    h264_mb_addr_gen #(
        .MB_W   (MB_W),
        .Y_BASE (Y_BASE),
        .U_BASE (U_BASE),
        .V_BASE (V_BASE)
    ) u_addr_gen (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .frame_start_i (frame_start),
        .mb_next_i     (mb_next),
        .adv_i         (acc),
        .col_last_i    (col_last),
        .row_last_i    (row_last),
        .plane_i       (cur_plane),
        .col_i         (col_q),
        .mb_x_i        (mb_x_q),
        .fetch_addr_o  (fetch_addr_o)
    );

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_plane_o = out_plane_q;
    assign out_row_o   = out_row_q;
    assign out_col_o   = out_col_q;
    assign mb_x_o      = mb_x_q;
    assign mb_y_o      = mb_y_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_h264_mb_fetch_ctrl.sv
// Directed bench for h264_mb_fetch_ctrl on an 11x9-MB frame with a
// combinational frame-memory model.
module tb_h264_mb_fetch_ctrl;

    localparam int MBW = 11;
    localparam int MBH = 9;
    localparam int YB  = 0;
    localparam int UB  = 6336;
    localparam int VB  = 7920;

    logic        clk = 1'b0;
    logic        rst_ni, start, data_valid, out_ready, mb_ack;
    logic [31:0] fetch_addr, data_word, out_data;
    logic        out_valid, mb_done, busy, frame_done;
    logic [1:0]  out_plane, out_col;
    logic [3:0]  out_row;
    logic [5:0]  mb_x, mb_y;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    assign data_word = mem_word(fetch_addr);

    h264_mb_fetch_ctrl #(
        .MB_W(MBW), .MB_H(MBH), .Y_BASE(32'd0), .U_BASE(32'd6336), .V_BASE(32'd7920)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_i      (start),
        .fetch_addr_o (fetch_addr),
        .data_word_i  (data_word),
        .data_valid_i (data_valid),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_plane_o  (out_plane),
        .out_row_o    (out_row),
        .out_col_o    (out_col),
        .mb_x_o       (mb_x),
        .mb_y_o       (mb_y),
        .mb_done_o    (mb_done),
        .mb_ack_i     (mb_ack),
        .busy_o       (busy),
        .frame_done_o (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference address of word k (0..95) of MB (mbx, mby), straight from the frame layout.
    function automatic logic [31:0] ref_addr(input int mbx, input int mby, input int k);
        int row, col;
        if (k < 64) begin
            row = k / 4; col = k % 4;
            return 32'(YB + (mby * 16 + row) * MBW * 4 + mbx * 4 + col);
        end
        row = ((k - 64) % 16) / 2; col = k % 2;
        return 32'(((k < 80) ? UB : VB) + (mby * 8 + row) * MBW * 2 + mbx * 2 + col);
    endfunction

    function automatic logic [7:0] ref_tag(input int k);
        logic [1:0] p;
        int row, col;
        p   = (k < 64) ? 2'd0 : ((k < 80) ? 2'd1 : 2'd2);
        row = (k < 64) ? k / 4 : ((k - 64) % 16) / 2;
        col = (k < 64) ? k % 4 : k % 2;
        return {p, 4'(row), 2'(col)};
    endfunction

    // Runs one MB from its first FETCH_Y cycle until its last word is taken downstream.
    // mode 0: free flow; mode 1: out_ready 1 on / 2 off; mode 2: data_valid gap at Y row 7 col 2.
    task automatic run_mb(input int mbx, input int mby, input int mode);
        int   n_acc = 0;
        int   n_out = 0;
        int   gap   = 0;
        int   cyc   = 0;
        logic m_valid = 1'b0;
        logic dv, rdy, acc, dn;
        while (n_out < 96 && cyc < 1000) begin
            rdy = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
            dv  = 1'b1;
            if (mode == 2 && n_acc == 30 && gap < 5) begin
                dv = 1'b0;
                gap++;
            end
            data_valid = dv;
            out_ready  = rdy;
            #1;
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (n_acc < 96) check("fetch_addr", fetch_addr, ref_addr(mbx, mby, n_acc));
            acc = (n_acc < 96) && dv && (!m_valid || rdy);
            dn  = m_valid && rdy;
            check("mb_done", 32'(mb_done), 32'(dn && n_acc == 96));
            if (dn) begin
                check("out_data", out_data, mem_word(ref_addr(mbx, mby, n_out)));
                check("out_tag", 32'({out_plane, out_row, out_col}), 32'(ref_tag(n_out)));
                n_out++;
            end
            if (acc) begin
                n_acc++;
                m_valid = 1'b1;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            if (n_out < 96) step();
            cyc++;
        end
        check("mb_words_delivered", 32'(n_out), 32'd96);
    endtask

    initial begin
        int cyc, n_done, n_fd, last_done, fd_cyc;

        rst_ni = 1'b0; start = 1'b0; data_valid = 1'b1; out_ready = 1'b1; mb_ack = 1'b1;
        step();
        step();
        check("rst_fetch_addr", fetch_addr, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_mb_xy", 32'({mb_x, mb_y}), 32'd0);
        check("rst_pulses", 32'({mb_done, frame_done}), 32'd0);

        // Full frame with everything tied high.
        rst_ni = 1'b1;
        step();
        check("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        run_mb(0, 0, 0);
        cyc = 96; n_done = 0; n_fd = 0; last_done = -1; fd_cyc = -1;
        while (cyc < 12000) begin
            if (mb_done) begin
                n_done++;
                if (last_done >= 0) check("mb_done_period", 32'(cyc - last_done), 32'd98);
                last_done = cyc;
            end
            if (frame_done) begin
                n_fd++;
                fd_cyc = cyc;
            end
            if (cyc / 98 == 25) begin
                if (cyc % 98 == 0) begin
                    check("mb32_y_addr", fetch_addr, 32'd1420);
                    check("mb32_xy", 32'({mb_x, mb_y}), 32'({6'd3, 6'd2}));
                end
                if (cyc % 98 == 64) check("mb32_u_addr", fetch_addr, 32'd6694);
                if (cyc % 98 == 80) check("mb32_v_addr", fetch_addr, 32'd8278);
            end
            if (frame_done) break;
            step();
            cyc++;
        end
        check("frame_done_cycle", 32'(fd_cyc), 32'd9702);
        check("mb_done_count", 32'(n_done), 32'd99);
        step();
        check("frame_done_once", 32'(n_fd + frame_done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_mb_xy", 32'({mb_x, mb_y}), 32'({6'd10, 6'd8}));

        // Back-pressured MB, then a long acknowledge hold.
        mb_ack = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        run_mb(0, 0, 1);
        out_ready = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            check("ack_hold_busy", 32'(busy), 32'd1);
            check("ack_hold_addr", fetch_addr, 32'd8075);
            check("ack_hold_valid", 32'(out_valid), 32'd0);
            step();
        end
        mb_ack = 1'b1;
        step();
        mb_ack = 1'b0;
        check("next_mb_addr", fetch_addr, 32'd4);
        check("next_mb_x", 32'(mb_x), 32'd1);

        // data_valid gap inside MB (1,0).
        run_mb(1, 0, 2);
        step();
        mb_ack = 1'b1;
        start = 1'b1;
        data_valid = 1'b1;
        out_ready = 1'b1;
        step();
        for (int i = 0; i < 361; i++) step();
        check("mb5_u_addr", fetch_addr, 32'd6369);
        check("mb5_u_tag", 32'({out_plane, out_row, out_col}), 32'h44);
        check("mb5_x", 32'(mb_x), 32'd5);

        // Reset mid-frame, then restart.
        start = 1'b0;
        rst_ni = 1'b0;
        step();
        check("mid_rst_addr", fetch_addr, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_tag", 32'({out_plane, out_row, out_col}), 32'd0);
        check("mid_rst_mb_xy", 32'({mb_x, mb_y}), 32'd0);
        step();
        check("mid_rst_hold_busy", 32'(busy), 32'd0);
        rst_ni = 1'b1;
        step();
        check("post_rst_idle", 32'(busy), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_addr", fetch_addr, 32'd0);
        step();
        check("restart_addr1", fetch_addr, 32'd1);
        check("restart_data", out_data, mem_word(32'd0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
